// File: rtl/riscpipe_pkg.sv
// Shared definitions for the pipelined RISC core: widths, ALUOp and opcode
// encodings, the decoded control bundle and the "instruction reads rt" rule.
package riscpipe_pkg;

    localparam int DATA_W_DEFAULT = 32;
    localparam int REG_W_DEFAULT  = 5;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;
    localparam logic [5:0] OPC_BEQ   = 6'h04;

    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    // rt is a source operand when the ALU takes its second input from the
    // register file (R-type, BEQ) or when a store writes rt to memory.
    function automatic logic uses_rt(input logic alu_src, input logic mem_write);
        return (!alu_src) || mem_write;
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Bundle between the decode stage and the ID/EX register: decoded ID fields
// and flush in, registered EX fields, stall and event counters out.
interface id_ex_stage_if
    import riscpipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int REG_W  = REG_W_DEFAULT,
    parameter int CNT_W  = 16
);
    logic              id_valid;
    logic              id_reg_dst, id_alu_src, id_mem_to_reg, id_reg_write;
    logic              id_mem_read, id_mem_write, id_branch;
    logic [1:0]        id_alu_op;
    logic [DATA_W-1:0] id_pc_plus4, id_rd1, id_rd2, id_imm;
    logic [REG_W-1:0]  id_rs, id_rt, id_rd;
    logic [5:0]        id_funct;
    logic              flush;

    logic              stall;
    logic              ex_valid;
    logic              ex_reg_dst, ex_alu_src, ex_mem_to_reg, ex_reg_write;
    logic              ex_mem_read, ex_mem_write, ex_branch;
    logic [1:0]        ex_alu_op;
    logic [DATA_W-1:0] ex_pc_plus4, ex_rd1, ex_rd2, ex_imm;
    logic [REG_W-1:0]  ex_rs, ex_rt, ex_rd;
    logic [5:0]        ex_funct;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;

    modport master (
        output id_valid, id_reg_dst, id_alu_src, id_mem_to_reg, id_reg_write,
               id_mem_read, id_mem_write, id_branch, id_alu_op,
               id_pc_plus4, id_rd1, id_rd2, id_imm, id_rs, id_rt, id_rd,
               id_funct, flush,
        input  stall, ex_valid, ex_reg_dst, ex_alu_src, ex_mem_to_reg,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_alu_op,
               ex_pc_plus4, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd,
               ex_funct, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_reg_dst, id_alu_src, id_mem_to_reg, id_reg_write,
               id_mem_read, id_mem_write, id_branch, id_alu_op,
               id_pc_plus4, id_rd1, id_rd2, id_imm, id_rs, id_rt, id_rd,
               id_funct, flush,
        output stall, ex_valid, ex_reg_dst, ex_alu_src, ex_mem_to_reg,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_alu_op,
               ex_pc_plus4, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd,
               ex_funct, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use check: the load now in EX writes a register that
// the instruction in ID reads, so ID must wait one cycle. $0 never hazards.
module load_use_detect
    import riscpipe_pkg::*;
#(
    parameter int REG_W = REG_W_DEFAULT
) (
    input  logic             ex_valid_i,
    input  logic             ex_mem_read_i,
    input  logic [REG_W-1:0] ex_rt_i,
    input  logic             id_valid_i,
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    input  logic             id_uses_rt_i,
    output logic             hazard_o
);

    logic ex_is_load;
    logic rs_match;
    logic rt_match;

    // Qualify the EX load and compare its destination against ID sources
    always_comb begin
        ex_is_load = ex_valid_i && ex_mem_read_i && (ex_rt_i != '0);
        rs_match   = (ex_rt_i == id_rs_i);
        rt_match   = id_uses_rt_i && (ex_rt_i == id_rt_i);
        hazard_o   = ex_is_load && id_valid_i && (rs_match || rt_match);
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register. Captures the decoded bundle each cycle, inserts a
// bubble on flush, load-use hazard or an empty ID slot, drives the stall to
// IF/ID and the PC, and keeps saturating stall/flush event counters.
module id_ex_stage
    import riscpipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int REG_W  = REG_W_DEFAULT,
    parameter int CNT_W  = 16
) (
    input  logic         clk,
    input  logic         rst,
    id_ex_stage_if.slave bus
);

    ctrl_t             id_ctrl;
    ctrl_t             ctrl_d, ctrl_q;
    logic              valid_d, valid_q;
    logic [DATA_W-1:0] pc_plus4_q, rd1_q, rd2_q, imm_q;
    logic [REG_W-1:0]  rs_q, rt_q, rd_q;
    logic [5:0]        funct_q;
    logic [CNT_W-1:0]  stall_cnt_d, stall_cnt_q;
    logic [CNT_W-1:0]  flush_cnt_d, flush_cnt_q;
    logic              hazard;
    logic              stall;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    load_use_detect #(
        .REG_W (REG_W)
    ) u_detect (
        .ex_valid_i    (valid_q),
        .ex_mem_read_i (ctrl_q.mem_read),
        .ex_rt_i       (rt_q),
        .id_valid_i    (bus.id_valid),
        .id_rs_i       (bus.id_rs),
        .id_rt_i       (bus.id_rt),
        .id_uses_rt_i  (uses_rt(bus.id_alu_src, bus.id_mem_write)),
        .hazard_o      (hazard)
    );

    // A flush squashes the ID instruction anyway, so it never needs to stall
    assign stall = hazard && !bus.flush;

    // Select the next control bundle (flush > hazard > normal) and counters
    always_comb begin
        id_ctrl = '{reg_dst:    bus.id_reg_dst,
                    alu_src:    bus.id_alu_src,
                    mem_to_reg: bus.id_mem_to_reg,
                    reg_write:  bus.id_reg_write,
                    mem_read:   bus.id_mem_read,
                    mem_write:  bus.id_mem_write,
                    branch:     bus.id_branch,
                    alu_op:     bus.id_alu_op};
        ctrl_d      = id_ctrl;
        valid_d     = bus.id_valid;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        if (bus.flush) begin
            ctrl_d  = CTRL_BUBBLE;
            valid_d = 1'b0;
        end else if (hazard) begin
            ctrl_d  = CTRL_BUBBLE;
            valid_d = 1'b0;
        end else if (!bus.id_valid) begin
            ctrl_d  = CTRL_BUBBLE;
            valid_d = 1'b0;
        end

        if (stall) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end
        if (bus.flush) begin
            flush_cnt_d = sat_inc(flush_cnt_q);
        end
    end

    // Register bank; data fields load unconditionally and are qualified
    // downstream by ex_valid and the control bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q      <= CTRL_BUBBLE;
            valid_q     <= 1'b0;
            pc_plus4_q  <= '0;
            rd1_q       <= '0;
            rd2_q       <= '0;
            imm_q       <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            rd_q        <= '0;
            funct_q     <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ctrl_q      <= ctrl_d;
            valid_q     <= valid_d;
            pc_plus4_q  <= bus.id_pc_plus4;
            rd1_q       <= bus.id_rd1;
            rd2_q       <= bus.id_rd2;
            imm_q       <= bus.id_imm;
            rs_q        <= bus.id_rs;
            rt_q        <= bus.id_rt;
            rd_q        <= bus.id_rd;
            funct_q     <= bus.id_funct;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.stall         = stall;
    assign bus.ex_valid      = valid_q;
    assign bus.ex_reg_dst    = ctrl_q.reg_dst;
    assign bus.ex_alu_src    = ctrl_q.alu_src;
    assign bus.ex_mem_to_reg = ctrl_q.mem_to_reg;
    assign bus.ex_reg_write  = ctrl_q.reg_write;
    assign bus.ex_mem_read   = ctrl_q.mem_read;
    assign bus.ex_mem_write  = ctrl_q.mem_write;
    assign bus.ex_branch     = ctrl_q.branch;
    assign bus.ex_alu_op     = ctrl_q.alu_op;
    assign bus.ex_pc_plus4   = pc_plus4_q;
    assign bus.ex_rd1        = rd1_q;
    assign bus.ex_rd2        = rd2_q;
    assign bus.ex_imm        = imm_q;
    assign bus.ex_rs         = rs_q;
    assign bus.ex_rt         = rt_q;
    assign bus.ex_rd         = rd_q;
    assign bus.ex_funct      = funct_q;
    assign bus.stall_cnt     = stall_cnt_q;
    assign bus.flush_cnt     = flush_cnt_q;

endmodule
